einstein_keyboard: RTL and testbench

EINSTEIN_KEYBOARD -- requirements
Module: einstein_keyboard

---
 rtl/einstein_kb_pkg.sv | 97 +++++++++
 rtl/ps2_rx.sv | 138 +++++++++++++
 rtl/einstein_keyboard.sv | 115 +++++++++++
 tb/tb_einstein_keyboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/einstein_kb_pkg.sv
// Shared types, scancode constants and the PS/2 set-2 to Einstein matrix map
// used by the keyboard adapter.
package einstein_kb_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_BAT    = 8'hAA;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_GRAPH  = 8'h11;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.valid = 1'b1;
        p.row   = row;
        p.col   = col;
        return p;
    endfunction

    // Index is {ext, code}; modifier and protocol bytes are deliberately absent.
    function automatic key_pos_t key_lookup(input logic ext, input logic [7:0] code);
        key_pos_t p;
        p = '{valid: 1'b0, row: 3'd0, col: 3'd0};
        case ({ext, code})
            9'h029: p = key_at(3'd0, 3'd0);
            9'h066: p = key_at(3'd0, 3'd1);
            9'h05A: p = key_at(3'd0, 3'd2);
            9'h00D: p = key_at(3'd0, 3'd3);
            9'h076: p = key_at(3'd0, 3'd4);
            9'h1C:  p = key_at(3'd1, 3'd4);
            9'h032: p = key_at(3'd1, 3'd5);
            9'h021: p = key_at(3'd1, 3'd6);
            9'h023: p = key_at(3'd1, 3'd7);
            9'h024: p = key_at(3'd2, 3'd0);
            9'h02B: p = key_at(3'd2, 3'd1);
            9'h034: p = key_at(3'd2, 3'd2);
            9'h033: p = key_at(3'd2, 3'd3);
            9'h043: p = key_at(3'd2, 3'd4);
            9'h03B: p = key_at(3'd2, 3'd5);
            9'h042: p = key_at(3'd2, 3'd6);
            9'h04B: p = key_at(3'd2, 3'd7);
            9'h03A: p = key_at(3'd3, 3'd0);
            9'h031: p = key_at(3'd3, 3'd1);
            9'h044: p = key_at(3'd3, 3'd2);
            9'h04D: p = key_at(3'd3, 3'd3);
            9'h015: p = key_at(3'd3, 3'd4);
            9'h02D: p = key_at(3'd3, 3'd5);
            9'h01B: p = key_at(3'd3, 3'd6);
            9'h02C: p = key_at(3'd3, 3'd7);
            9'h03C: p = key_at(3'd4, 3'd0);
            9'h02A: p = key_at(3'd4, 3'd1);
            9'h01D: p = key_at(3'd4, 3'd2);
            9'h022: p = key_at(3'd4, 3'd3);
            9'h035: p = key_at(3'd4, 3'd4);
            9'h01A: p = key_at(3'd4, 3'd5);
            9'h045: p = key_at(3'd5, 3'd0);
            9'h016: p = key_at(3'd5, 3'd1);
            9'h01E: p = key_at(3'd5, 3'd2);
            9'h026: p = key_at(3'd5, 3'd3);
            9'h025: p = key_at(3'd5, 3'd4);
            9'h02E: p = key_at(3'd5, 3'd5);
            9'h036: p = key_at(3'd5, 3'd6);
            9'h03D: p = key_at(3'd5, 3'd7);
            9'h03E: p = key_at(3'd6, 3'd0);
            9'h046: p = key_at(3'd6, 3'd1);
            9'h175: p = key_at(3'd7, 3'd0);
            9'h172: p = key_at(3'd7, 3'd1);
            9'h16B: p = key_at(3'd7, 3'd2);
            9'h174: p = key_at(3'd7, 3'd3);
            9'h171: p = key_at(3'd7, 3'd4);
            9'h16C: p = key_at(3'd7, 3'd5);
            9'h15A: p = key_at(3'd0, 3'd2);
            default: p = '{valid: 1'b0, row: 3'd0, col: 3'd0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizers, clock glitch filter, frame FSM
// and inactivity timeout. Emits one byte/valid pulse or one error pulse per frame.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    import einstein_kb_pkg::*;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic [FW-1:0] filt_cnt_r;
    logic          filt_clk_r, filt_prev_r;
    logic          fall_s;
    rx_state_t     state_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [TW-1:0] to_cnt_r;
    logic [7:0]    rx_byte_r;
    logic          rx_valid_r, rx_err_r;

    // Two-stage synchronizers for the raw PS/2 lines; idle level is high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Filtered clock follows the synchronized clock only after a run of
    // FILTER_LEN disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_r  <= '0;
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_sync_r == filt_clk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_clk_r <= clk_sync_r;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + {{(FW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fall_s = filt_prev_r & ~filt_clk_r;

    // Frame FSM and timeout; a falling edge takes priority over expiry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= RX_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            to_cnt_r   <= '0;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    RX_IDLE: begin
                        bit_cnt_r <= 3'd0;
                        if (!data_sync_r) begin
                            state_r <= RX_DATA;
                        end else begin
                            state_r <= RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        shift_r   <= {data_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= RX_PARITY;
                        end else begin
                            state_r <= RX_DATA;
                        end
                    end
                    RX_PARITY: begin
                        if (odd_parity_ok(shift_r, data_sync_r)) begin
                            state_r <= RX_STOP;
                        end else begin
                            state_r  <= RX_IDLE;
                            rx_err_r <= 1'b1;
                        end
                    end
                    RX_STOP: begin
                        state_r <= RX_IDLE;
                        if (data_sync_r) begin
                            rx_byte_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            rx_err_r <= 1'b1;
                        end
                    end
                    default: state_r <= RX_IDLE;
                endcase
            end else if (state_r != RX_IDLE) begin
                if (to_cnt_r == TW'(TIMEOUT)) begin
                    state_r  <= RX_IDLE;
                    to_cnt_r <= '0;
                    rx_err_r <= 1'b1;
                end else begin
                    to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    assign rx_byte  = rx_byte_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;

endmodule

// File: rtl/einstein_keyboard.sv
// PS/2 keyboard to Tatung Einstein 8x8 matrix adapter: scancode decoder,
// pressed-key matrix, modifier lines and the active-low column read-back.
module einstein_keyboard #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] kb_row,
    output logic [7:0] kb_col,
    output logic       kb_shift,
    output logic       kb_ctrl,
    output logic       kb_graph,
    output logic       key_strobe,
    output logic       frame_err
);
    import einstein_kb_pkg::*;

    logic [7:0]      rx_byte_s;
    logic            rx_valid_s, rx_err_s;
    key_pos_t        pos_s;
    logic [7:0][7:0] matrix_r;
    logic            ext_r, brk_r;
    logic            lshift_r, rshift_r, ctrl_r, graph_r;
    logic            key_strobe_r, frame_err_r;
    logic [7:0]      col_hit_s;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_err   (rx_err_s)
    );

    // Matrix position of the current byte in the context of the prefix flags.
    always_comb begin
        pos_s = key_lookup(ext_r, rx_byte_s);
    end

    // Scancode decoder: prefixes set flags, every other byte consumes them.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            matrix_r     <= '0;
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            lshift_r     <= 1'b0;
            rshift_r     <= 1'b0;
            ctrl_r       <= 1'b0;
            graph_r      <= 1'b0;
            key_strobe_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            key_strobe_r <= rx_valid_s;
            frame_err_r  <= rx_err_s;
            if (rx_valid_s) begin
                if (rx_byte_s == CODE_EXT) begin
                    ext_r <= 1'b1;
                end else if (rx_byte_s == CODE_BRK) begin
                    brk_r <= 1'b1;
                end else begin
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                    // Shift/graph with E0 are fake or right-hand variants; only ctrl accepts both.
                    if (rx_byte_s == CODE_BAT) begin
                        matrix_r <= '0;
                        lshift_r <= 1'b0;
                        rshift_r <= 1'b0;
                        ctrl_r   <= 1'b0;
                        graph_r  <= 1'b0;
                    end else if (rx_byte_s == CODE_LSHIFT && !ext_r) begin
                        lshift_r <= ~brk_r;
                    end else if (rx_byte_s == CODE_RSHIFT && !ext_r) begin
                        rshift_r <= ~brk_r;
                    end else if (rx_byte_s == CODE_CTRL) begin
                        ctrl_r <= ~brk_r;
                    end else if (rx_byte_s == CODE_GRAPH && !ext_r) begin
                        graph_r <= ~brk_r;
                    end else if (pos_s.valid) begin
                        matrix_r[pos_s.row][pos_s.col] <= ~brk_r;
                    end else begin
                        matrix_r <= matrix_r;
                    end
                end
            end
        end
    end

    // Selected rows pull their pressed columns low (wired-AND on the bus).
    always_comb begin
        col_hit_s = 8'h00;
        for (int r = 0; r < 8; r++) begin
            if (!kb_row[r]) begin
                col_hit_s = col_hit_s | matrix_r[r];
            end else begin
                col_hit_s = col_hit_s;
            end
        end
    end

    assign kb_col     = ~col_hit_s;
    assign kb_shift   = ~(lshift_r | rshift_r);
    assign kb_ctrl    = ~ctrl_r;
    assign kb_graph   = ~graph_r;
    assign key_strobe = key_strobe_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_einstein_keyboard.sv
// Directed plus randomized bench for einstein_keyboard against a key-set model.
module tb_einstein_keyboard;

    localparam int HP = 24;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kb_row   = 8'hFF;
    logic [7:0] kb_col;
    logic       kb_shift, kb_ctrl, kb_graph, key_strobe, frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;
    int err_cnt     = 0;
    logic [7:0] col_at_strobe = 8'hFF;

    // Reference model: which of the three known keys and four modifiers are held.
    logic key_dn [3];
    logic lsh, rsh, ctl, gph;
    int   key_row_of [3] = '{1, 0, 7};
    int   key_col_of [3] = '{4, 2, 0};
    logic [7:0] specials [5] = '{8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    einstein_keyboard dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kb_row     (kb_row),
        .kb_col     (kb_col),
        .kb_shift   (kb_shift),
        .kb_ctrl    (kb_ctrl),
        .kb_graph   (kb_graph),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #25 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (key_strobe === 1'b1) begin
            strobe_cnt++;
            col_at_strobe = kb_col;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HP);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = (~(^b)) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(HP);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    function automatic logic [7:0] exp_col(input logic [7:0] row);
        logic [7:0] c;
        c = 8'hFF;
        for (int k = 0; k < 3; k++)
            if (key_dn[k] && !row[key_row_of[k]]) c[key_col_of[k]] = 1'b0;
        return c;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) key_dn[k] = 1'b0;
        lsh = 1'b0; rsh = 1'b0; ctl = 1'b0; gph = 1'b0;
    endtask

    // k: 0=1C 1=5A 2=E0 75 3=lshift 4=rshift 5=ctrl 6=graph
    task automatic apply_key(input int k, input logic brk, output int nbytes);
        logic use_ext;
        use_ext = (k == 2) || (k == 5 && $urandom_range(0, 1) == 1);
        nbytes = 1;
        if (use_ext) begin send(8'hE0); nbytes++; end
        if (brk) begin send(8'hF0); nbytes++; end
        case (k)
            0: begin send(8'h1C); key_dn[0] = ~brk; end
            1: begin send(8'h5A); key_dn[1] = ~brk; end
            2: begin send(8'h75); key_dn[2] = ~brk; end
            3: begin send(8'h12); lsh = ~brk; end
            4: begin send(8'h59); rsh = ~brk; end
            5: begin send(8'h14); ctl = ~brk; end
            default: begin send(8'h11); gph = ~brk; end
        endcase
    endtask

    task automatic check_state(input string tag);
        @(negedge clk_sys);
        check({tag, "_col"},   kb_col, exp_col(kb_row));
        check({tag, "_shift"}, {7'd0, kb_shift}, {7'd0, ~(lsh | rsh)});
        check({tag, "_ctrl"},  {7'd0, kb_ctrl},  {7'd0, ~ctl});
        check({tag, "_graph"}, {7'd0, kb_graph}, {7'd0, ~gph});
    endtask

    initial begin
        int s0, e0, n;
        logic [7:0] glitch_byte;
        clear_model();

        // Reset state
        kb_row = 8'h00;
        tick(3);
        @(negedge clk_sys);
        check("rst_col",    kb_col, 8'hFF);
        check("rst_mods",   {5'd0, kb_shift, kb_ctrl, kb_graph}, 8'h07);
        check("rst_pulses", {6'd0, key_strobe, frame_err}, 8'h00);
        reset_n = 1'b1;
        tick(4);

        // Single make code
        kb_row = 8'hFD;
        s0 = strobe_cnt; e0 = err_cnt;
        send(8'h1C);
        key_dn[0] = 1'b1;
        check("make_strobes", 8'(strobe_cnt - s0), 8'd1);
        check("make_col_at_strobe", col_at_strobe, 8'hEF);
        check_state("make");

        // Break sequence
        s0 = strobe_cnt;
        send(8'hF0);
        send(8'h1C);
        key_dn[0] = 1'b0;
        check("break_strobes", 8'(strobe_cnt - s0), 8'd2);
        check("break_errs", 8'(err_cnt - e0), 8'd0);
        check("break_col", kb_col, 8'hFF);

        // Bad parity
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        tick(HP);
        check("par_errs", 8'(err_cnt - e0), 8'd1);
        check("par_strobes", 8'(strobe_cnt - s0), 8'd0);
        check_state("par");

        // Partial frame then timeout, then a good frame
        e0 = err_cnt;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        for (int i = 0; i < 25000 && err_cnt == e0; i++) tick(1);
        tick(HP);
        check("timeout_errs", 8'(err_cnt - e0), 8'd1);
        send(8'h5A);
        key_dn[1] = 1'b1;
        kb_row = 8'hFE;
        @(negedge clk_sys);
        check("after_timeout_col", kb_col, 8'hFB);
        send(8'hF0); send(8'h5A);
        key_dn[1] = 1'b0;

        // Independent shift tracking
        send(8'h12); send(8'h59);
        lsh = 1'b1; rsh = 1'b1;
        send(8'hF0); send(8'h12);
        lsh = 1'b0;
        check("shift_one_left", {7'd0, kb_shift}, 8'd0);
        send(8'hF0); send(8'h59);
        rsh = 1'b0;
        check("shift_none", {7'd0, kb_shift}, 8'd1);

        // Multi-row wired-AND, BAT release, clock glitch rejection
        send(8'h1C); send(8'hE0); send(8'h75);
        key_dn[0] = 1'b1; key_dn[2] = 1'b1;
        kb_row = 8'h7D;
        @(negedge clk_sys);
        check("multirow_col", kb_col, 8'hEE);
        send(8'hAA);
        clear_model();
        check("bat_col", kb_col, 8'hFF);
        s0 = strobe_cnt; e0 = err_cnt;
        glitch_byte = 8'h1C;
        for (int i = 0; i < 8; i++) begin
            ps2_data = glitch_byte[i];
            tick(HP);
            ps2_clk = 1'b0;
            tick(4);
            ps2_clk = 1'b1;
            tick(HP);
        end
        ps2_data = 1'b1;
        tick(HP);
        check("glitch_strobes", 8'(strobe_cnt - s0), 8'd0);
        check("glitch_errs", 8'(err_cnt - e0), 8'd0);
        check_state("glitch");

        // Randomized sequences against the model
        for (int it = 0; it < 24; it++) begin
            int act;
            act = $urandom_range(0, 9);
            s0 = strobe_cnt; e0 = err_cnt;
            if (act <= 6) begin
                apply_key(act, 1'($urandom_range(0, 1)), n);
            end else if (act <= 8) begin
                send(specials[$urandom_range(0, 4)]);
                n = 1;
            end else begin
                send(8'hAA);
                clear_model();
                n = 1;
            end
            kb_row = 8'($urandom);
            check("rnd_strobes", 8'(strobe_cnt - s0), 8'(n));
            check("rnd_errs", 8'(err_cnt - e0), 8'd0);
            check_state("rnd");
        end

        // Reset in mid-frame discards silently
        send(8'h1C);
        key_dn[0] = 1'b1;
        e0 = err_cnt;
        ps2_bit(1'b0); ps2_bit(1'b1);
        reset_n = 1'b0;
        clear_model();
        kb_row = 8'h00;
        tick(2);
        @(negedge clk_sys);
        check("midrst_col", kb_col, 8'hFF);
        reset_n = 1'b1;
        tick(TIMEOUT_GUARD());
        check("midrst_errs", 8'(err_cnt - e0), 8'd0);
        s0 = strobe_cnt;
        send(8'h5A);
        key_dn[1] = 1'b1;
        check("midrst_strobes", 8'(strobe_cnt - s0), 8'd1);
        check_state("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic int TIMEOUT_GUARD();
        return 4 * HP;
    endfunction

endmodule
